// File: rtl/trng_crngt_ctrl.sv
// Sequencer for the TRNG entropy path: clear, warm-up, collect into the EHR, hand off to the host.
// Optional macro TRNG_CRNGT_AUTO_RETRY_EN: a failed attempt restarts from CLEAR up to MAX_RETRY times.
module trng_crngt_ctrl #(
    parameter int WARMUP_W   = 16,
    parameter int TIMEOUT_W  = 20,
    parameter int WORDS      = 12,
    parameter int ERR_THRESH = 4,
    parameter int MAX_RETRY  = 3
) (
    input  logic                 rng_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WARMUP_W-1:0]  warmup_cycles,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 crngt_valid,
    input  logic                 crngt_err,
    input  logic                 ehr_ack,
    output logic                 rnd_src_en,
    output logic                 rst_trng_logic,
    output logic                 trng_valid,
    output logic                 ehr_wr,
    output logic [3:0]           ehr_idx,
    output logic                 busy,
    output logic                 done_irq,
    output logic                 err_irq,
    output logic                 timeout_irq,
    output logic [7:0]           err_cnt,
    output logic [1:0]           retry_cnt
);

    typedef enum logic [2:0] {IDLE, CLEAR, WARMUP, COLLECT, FULL, FAIL} state_e;

    localparam logic [3:0] LastIdx   = 4'(WORDS - 1);
    localparam logic [8:0] ErrThresh = 9'(ERR_THRESH);

    state_e                state_q;
    logic [WARMUP_W-1:0]   warmCnt_q;
    logic [TIMEOUT_W-1:0]  wdCnt_q;
    logic [3:0]            idx_q;
    logic [7:0]            errCnt_q, errCnt_d;
    logic [1:0]            retry_q;
    logic                  rndEn_q, rstLogic_q, valid_q, busy_q;
    logic                  doneIrq_q, errIrq_q, toIrq_q;
    logic                  errHit, wdHit, lastWord;

    assign ehr_wr         = (state_q == COLLECT) && crngt_valid;
    assign ehr_idx        = idx_q;
    assign rnd_src_en     = rndEn_q;
    assign rst_trng_logic = rstLogic_q;
    assign trng_valid     = valid_q;
    assign busy           = busy_q;
    assign done_irq       = doneIrq_q;
    assign err_irq        = errIrq_q;
    assign timeout_irq    = toIrq_q;
    assign err_cnt        = errCnt_q;
    assign retry_cnt      = retry_q;

    always_comb begin
        errCnt_d = errCnt_q;
        if (crngt_err && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
        errHit   = crngt_err && (({1'b0, errCnt_q} + 9'd1) >= ErrThresh);
        wdHit    = (wdCnt_q == TIMEOUT_W'(1));
        lastWord = ehr_wr && (idx_q == LastIdx);
    end

    // Outputs are registered alongside the state so each one changes on the same edge as its state.
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            warmCnt_q  <= '0;
            wdCnt_q    <= '0;
            idx_q      <= '0;
            errCnt_q   <= '0;
            retry_q    <= '0;
            rndEn_q    <= 1'b0;
            rstLogic_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            doneIrq_q  <= 1'b0;
            errIrq_q   <= 1'b0;
            toIrq_q    <= 1'b0;
        end else begin
            rstLogic_q <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
                rndEn_q <= 1'b0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            doneIrq_q  <= 1'b0;
                            errIrq_q   <= 1'b0;
                            toIrq_q    <= 1'b0;
                            errCnt_q   <= '0;
                            retry_q    <= '0;
                            idx_q      <= '0;
                            rstLogic_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        warmCnt_q <= warmup_cycles;
                        rndEn_q   <= 1'b1;
                        state_q   <= WARMUP;
                    end
                    WARMUP: begin
                        // A load of 0 or 1 both give a single warm-up cycle.
                        if (warmCnt_q != '0) begin
                            warmCnt_q <= warmCnt_q - 1'b1;
                        end
                        if (warmCnt_q <= WARMUP_W'(1)) begin
                            wdCnt_q <= timeout_cycles;
                            state_q <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (ehr_wr) begin
                            idx_q <= idx_q + 4'd1;
                        end
                        errCnt_q <= errCnt_d;
                        if (wdCnt_q != '0) begin
                            wdCnt_q <= wdCnt_q - 1'b1;
                        end
                        if (errHit || wdHit) begin
                            if (wdHit) begin
                                toIrq_q <= 1'b1;
                            end
                            rndEn_q <= 1'b0;
                            state_q <= FAIL;
                        end else if (lastWord) begin
                            doneIrq_q <= 1'b1;
                            valid_q   <= 1'b1;
                            rndEn_q   <= 1'b0;
                            state_q   <= FULL;
                        end
                    end
                    FULL: begin
                        if (ehr_ack) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    FAIL: begin
`ifdef TRNG_CRNGT_AUTO_RETRY_EN
                        if (int'(retry_q) < MAX_RETRY) begin
                            retry_q    <= retry_q + 2'd1;
                            errCnt_q   <= '0;
                            idx_q      <= '0;
                            rstLogic_q <= 1'b1;
                            state_q    <= CLEAR;
                        end else begin
                            errIrq_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
`else
                        errIrq_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
`endif
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trng_crngt_ctrl.sv
// Bench for trng_crngt_ctrl: directed sequences, EHR write indices checked through a scoreboard queue.
module tb_trng_crngt_ctrl;

    logic        clock;
    logic        resetN;
    logic        start;
    logic        stop;
    logic [15:0] warmupCycles;
    logic [19:0] timeoutCycles;
    logic        crngtValid;
    logic        crngtErr;
    logic        ehrAck;
    logic        rndSrcEn;
    logic        rstTrngLogic;
    logic        trngValid;
    logic        ehrWr;
    logic [3:0]  ehrIdx;
    logic        busy;
    logic        doneIrq;
    logic        errIrq;
    logic        timeoutIrq;
    logic [7:0]  errCnt;
    logic [1:0]  retryCnt;

    int          checks = 0;
    int          errors = 0;
    int          rstPulses = 0;
    int          base;
    logic [3:0]  expIdx[$];
    logic [3:0]  expHead;

    trng_crngt_ctrl #(
        .WARMUP_W  (16),
        .TIMEOUT_W (20),
        .WORDS     (12),
        .ERR_THRESH(4),
        .MAX_RETRY (3)
    ) dut (
        .rng_clk       (clock),
        .rst_n         (resetN),
        .start         (start),
        .stop          (stop),
        .warmup_cycles (warmupCycles),
        .timeout_cycles(timeoutCycles),
        .crngt_valid   (crngtValid),
        .crngt_err     (crngtErr),
        .ehr_ack       (ehrAck),
        .rnd_src_en    (rndSrcEn),
        .rst_trng_logic(rstTrngLogic),
        .trng_valid    (trngValid),
        .ehr_wr        (ehrWr),
        .ehr_idx       (ehrIdx),
        .busy          (busy),
        .done_irq      (doneIrq),
        .err_irq       (errIrq),
        .timeout_irq   (timeoutIrq),
        .err_cnt       (errCnt),
        .retry_cnt     (retryCnt)
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case some sequence never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "[TB] global timeout");
    end

    // Monitor: pops the expected EHR index on every write strobe and counts clear pulses.
    always @(negedge clock) begin
        if (rstTrngLogic === 1'b1) begin
            rstPulses++;
        end
        if (ehrWr === 1'b1) begin
            checks++;
            if (expIdx.size() == 0) begin
                errors++;
                $display("[TB] FAIL ehr_write: unexpected write at index %0d, required no write", ehrIdx);
            end else begin
                expHead = expIdx.pop_front();
                if (ehrIdx !== expHead) begin
                    errors++;
                    $display("[TB] FAIL ehr_write: index %0d, required %0d", ehrIdx, expHead);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tickN(input int n);
        repeat (n) tick();
    endtask

    task automatic pushRange(input int n);
        for (int i = 0; i < n; i++) begin
            expIdx.push_back(4'(i));
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " rnd_src_en"}, 32'(rndSrcEn), 0);
        checkOutput({tag, " rst_trng_logic"}, 32'(rstTrngLogic), 0);
        checkOutput({tag, " trng_valid"}, 32'(trngValid), 0);
        checkOutput({tag, " ehr_wr"}, 32'(ehrWr), 0);
        checkOutput({tag, " ehr_idx"}, 32'(ehrIdx), 0);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " irqs"}, {29'd0, doneIrq, errIrq, timeoutIrq}, 0);
        checkOutput({tag, " err_cnt"}, 32'(errCnt), 0);
        checkOutput({tag, " retry_cnt"}, 32'(retryCnt), 0);
    endtask

    // Pulses start for one cycle; returns one edge later, in the CLEAR cycle.
    task automatic applyStimulus(input logic [15:0] warm, input logic [19:0] tmo);
        warmupCycles  = warm;
        timeoutCycles = tmo;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        resetN = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        warmupCycles = '0;
        timeoutCycles = '0;
        crngtValid = 1'b0;
        crngtErr = 1'b0;
        ehrAck = 1'b0;
        tickN(2);
        checkAllZero("reset");
        resetN = 1'b1;
        tick();

        $display("[TB] nominal fill");
        crngtValid = 1'b1;
        pushRange(12);
        applyStimulus(16'd5, 20'd0);
        checkOutput("clear pulse", 32'(rstTrngLogic), 1);
        checkOutput("busy after start", 32'(busy), 1);
        checkOutput("source off in clear", 32'(rndSrcEn), 0);
        tick();
        checkOutput("clear lasts one cycle", 32'(rstTrngLogic), 0);
        checkOutput("source on in warmup", 32'(rndSrcEn), 1);
        tickN(4);
        checkOutput("no write in warmup", 32'(ehrWr), 0);
        tick();
        checkOutput("first write cycle 7", 32'(ehrWr), 1);
        checkOutput("first index", 32'(ehrIdx), 0);
        tickN(11);
        checkOutput("last index", 32'(ehrIdx), 11);
        checkOutput("valid low before full", 32'(trngValid), 0);
        tick();
        checkOutput("trng_valid cycle 19", 32'(trngValid), 1);
        checkOutput("done_irq", 32'(doneIrq), 1);
        checkOutput("source off in full", 32'(rndSrcEn), 0);
        checkOutput("no write in full", 32'(ehrWr), 0);
        crngtValid = 1'b0;
        ehrAck = 1'b1;
        tick();
        ehrAck = 1'b0;
        checkOutput("valid drops after ack", 32'(trngValid), 0);
        checkOutput("idle after ack", 32'(busy), 0);
        checkOutput("done_irq sticky", 32'(doneIrq), 1);

`ifndef TRNG_CRNGT_AUTO_RETRY_EN
        $display("[TB] error threshold");
        applyStimulus(16'd0, 20'd0);
        checkOutput("start clears done_irq", 32'(doneIrq), 0);
        tickN(2);
        crngtErr = 1'b1;
        tickN(3);
        checkOutput("err_cnt below threshold", 32'(errCnt), 3);
        checkOutput("source on below threshold", 32'(rndSrcEn), 1);
        tick();
        crngtErr = 1'b0;
        checkOutput("err_cnt at threshold", 32'(errCnt), 4);
        checkOutput("source off in fail", 32'(rndSrcEn), 0);
        checkOutput("busy in fail", 32'(busy), 1);
        checkOutput("err_irq not yet", 32'(errIrq), 0);
        tick();
        checkOutput("err_irq after fail", 32'(errIrq), 1);
        checkOutput("idle after fail", 32'(busy), 0);
        checkOutput("retry_cnt stays 0", 32'(retryCnt), 0);
`endif

        $display("[TB] watchdog");
        applyStimulus(16'd0, 20'd100);
        checkOutput("start clears err_irq", 32'(errIrq), 0);
        tickN(101);
        checkOutput("no timeout at cycle 102", 32'(timeoutIrq), 0);
        tick();
        checkOutput("timeout at cycle 103", 32'(timeoutIrq), 1);
        checkOutput("source off after timeout", 32'(rndSrcEn), 0);
`ifndef TRNG_CRNGT_AUTO_RETRY_EN
        tick();
        checkOutput("timeout also sets err_irq", 32'(errIrq), 1);
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("idle after timeout", 32'(busy), 0);

        $display("[TB] watchdog disabled");
        applyStimulus(16'd0, 20'd0);
        tickN(10000);
        checkOutput("no timeout when disabled", 32'(timeoutIrq), 0);
        checkOutput("still collecting", 32'(rndSrcEn), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop in collect source", 32'(rndSrcEn), 0);
        checkOutput("stop in collect busy", 32'(busy), 0);

        $display("[TB] stop during warmup");
        applyStimulus(16'd20, 20'd0);
        tickN(2);
        checkOutput("warming up", 32'(rndSrcEn), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop in warmup source", 32'(rndSrcEn), 0);
        checkOutput("stop in warmup busy", 32'(busy), 0);
        tickN(25);
        checkOutput("stays idle after stop", 32'(busy), 0);

        $display("[TB] start ignored, stop during full");
        crngtValid = 1'b1;
        pushRange(12);
        applyStimulus(16'd0, 20'd0);
        tickN(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start ignored in collect", 32'(rstTrngLogic), 0);
        checkOutput("index continues", 32'(ehrIdx), 3);
        tickN(9);
        checkOutput("full reached", 32'(trngValid), 1);
        crngtValid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop in full valid", 32'(trngValid), 0);
        checkOutput("stop in full busy", 32'(busy), 0);
        checkOutput("irq kept on stop", 32'(doneIrq), 1);

        $display("[TB] async reset mid-collect");
        crngtValid = 1'b1;
        pushRange(6);
        applyStimulus(16'd0, 20'd0);
        tickN(7);
        checkOutput("index before reset", 32'(ehrIdx), 5);
        @(negedge clock);
        #2;
        resetN = 1'b0;
        #1;
        checkAllZero("async reset");
        crngtValid = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        tick();
        crngtValid = 1'b1;
        pushRange(12);
        applyStimulus(16'd0, 20'd0);
        tickN(2);
        checkOutput("fresh start write", 32'(ehrWr), 1);
        checkOutput("fresh start index", 32'(ehrIdx), 0);
        tickN(12);
        checkOutput("fresh fill full", 32'(trngValid), 1);
        crngtValid = 1'b0;
        ehrAck = 1'b1;
        tick();
        ehrAck = 1'b0;

`ifdef TRNG_CRNGT_AUTO_RETRY_EN
        $display("[TB] auto retry exhausted");
        base = rstPulses;
        crngtErr = 1'b1;
        applyStimulus(16'd0, 20'd0);
        for (int i = 0; i < 200 && busy; i++) begin
            tick();
        end
        crngtErr = 1'b0;
        tick();
        checkOutput("retry run ends", 32'(busy), 0);
        checkOutput("clear pulses total", 32'(rstPulses - base), 4);
        checkOutput("retry_cnt exhausted", 32'(retryCnt), 3);
        checkOutput("err_irq after retries", 32'(errIrq), 1);

        $display("[TB] auto retry recovers");
        base = rstPulses;
        crngtErr = 1'b1;
        applyStimulus(16'd0, 20'd0);
        for (int i = 0; i < 50 && (rstPulses - base) < 2; i++) begin
            tick();
        end
        crngtErr = 1'b0;
        crngtValid = 1'b1;
        pushRange(12);
        for (int i = 0; i < 50 && !trngValid; i++) begin
            tick();
        end
        crngtValid = 1'b0;
        checkOutput("retry fill full", 32'(trngValid), 1);
        checkOutput("retry fill done_irq", 32'(doneIrq), 1);
        checkOutput("retry fill retry_cnt", 32'(retryCnt), 1);
        ehrAck = 1'b1;
        tick();
        ehrAck = 1'b0;
`endif

        tickN(2);
        checkOutput("scoreboard drained", 32'(expIdx.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
